// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic-gate self-test checker: FSM encoding, gate bit order, helpers.
package logic_gate_pkg;

    localparam int NUM_GATES = 7;

    localparam int AND_BIT  = 0;
    localparam int OR_BIT   = 1;
    localparam int NOT_BIT  = 2;
    localparam int NAND_BIT = 3;
    localparam int NOR_BIT  = 4;
    localparam int XOR_BIT  = 5;
    localparam int XNOR_BIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

    function automatic logic [3:0] popcount(input gate_vec_t v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/logic_gate_expect.sv
// Golden truth table for the gate unit: expected outputs for a given a/b, in fail_vec bit order.
module logic_gate_expect
    import logic_gate_pkg::*;
(
    input  logic      a,
    input  logic      b,
    output gate_vec_t expected
);

    always_comb begin
        expected           = '0;
        expected[AND_BIT]  = a & b;
        expected[OR_BIT]   = a | b;
        expected[NOT_BIT]  = ~a;
        expected[NAND_BIT] = ~(a & b);
        expected[NOR_BIT]  = ~(a | b);
        expected[XOR_BIT]  = a ^ b;
        expected[XNOR_BIT] = ~(a ^ b);
    end

endmodule

// File: rtl/logic_gate_tester.sv
// Sweeps a/b over all four vectors LOOPS times and records per-gate mismatches.
// Optional first-failure capture is enabled with `define LOGIC_GATE_TESTER_FIRST_FAIL_EN.
module logic_gate_tester
    import logic_gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_vec,
    output logic [7:0] err_count
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
   ,output logic       first_fail_valid,
    output logic [1:0] first_fail_idx,
    output logic [6:0] first_fail_obs
`endif
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [LW-1:0]   loop_q, loop_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            a_q, a_d, b_q, b_d;
    gate_vec_t       fail_q, fail_d;
    logic [7:0]      err_q, err_d;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
    logic            ff_valid_q, ff_valid_d;
    logic [1:0]      ff_idx_q, ff_idx_d;
    gate_vec_t       ff_obs_q, ff_obs_d;
`endif

    gate_vec_t       expected;
    gate_vec_t       observed;
    gate_vec_t       mismatch;
    logic [8:0]      err_sum;

    logic_gate_expect u_expect (
        .a        (a_q),
        .b        (b_q),
        .expected (expected)
    );

    always_comb begin
        observed           = '0;
        observed[AND_BIT]  = and_in;
        observed[OR_BIT]   = or_in;
        observed[NOT_BIT]  = not_in;
        observed[NAND_BIT] = nand_in;
        observed[NOR_BIT]  = nor_in;
        observed[XOR_BIT]  = xor_in;
        observed[XNOR_BIT] = xnor_in;
    end

    assign mismatch = observed ^ expected;
    assign err_sum  = {1'b0, err_q} + 9'(popcount(mismatch));

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        loop_d   = loop_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        fail_d   = fail_q;
        err_d    = err_q;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_obs_d   = ff_obs_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    loop_d  = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    fail_d  = '0;
                    err_d   = '0;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
                    ff_valid_d = 1'b0;
                    ff_idx_d   = '0;
                    ff_obs_d   = '0;
`endif
                end
            end
            ST_DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_CHECK: begin
                fail_d = fail_q | mismatch;
                err_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
                if (!ff_valid_q && (mismatch != '0)) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = idx_q;
                    ff_obs_d   = observed;
                end
`endif
                // The next vector is registered onto a/b on the same edge that enters DRIVE.
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    state_d = ST_DRIVE;
                end else if (loop_q != LOOP_LAST) begin
                    loop_d  = loop_q + LW'(1);
                    idx_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            loop_q   <= '0;
            settle_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            fail_q   <= '0;
            err_q    <= '0;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_obs_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            loop_q   <= loop_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_obs_q   <= ff_obs_d;
`endif
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = (fail_q == '0);
    assign fail_vec  = fail_q;
    assign err_count = err_q;
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_obs   = ff_obs_q;
`endif

endmodule

// File: tb/tb_logic_gate_tester.sv
// Self-checking bench: three checker instances (LOOPS 1/3/10), each facing a faultable gate-unit model.
module tb_logic_gate_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_i;
    logic [2:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [6:0] fail_o [3];
    logic [7:0] err_o  [3];
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
    logic [2:0] ffv_o;
    logic [1:0] ffi_o [3];
    logic [6:0] ffo_o [3];
`endif

    // Fault configuration of each gate-unit model: stuck bits, xor/xnor swap, per-vector flips.
    logic [6:0] sm [3];
    logic [6:0] sv [3];
    logic       sw [3];
    logic [6:0] flip [3][4];

    int loops_of  [3] = '{1, 3, 10};
    int settle_of [3] = '{1, 1, 0};

    int checks = 0;
    int errors = 0;
    logic [1:0] ab_seq [$];

    // Correct gate outputs from plain arithmetic on a and b (bit order AND..XNOR).
    function automatic logic [6:0] truth(input logic a, input logic b);
        int ai, bi, s;
        logic [6:0] t;
        ai = int'(a);
        bi = int'(b);
        s  = ai + bi;
        t[0] = (ai * bi) == 1;
        t[1] = s > 0;
        t[2] = ai == 0;
        t[3] = (ai * bi) == 0;
        t[4] = s == 0;
        t[5] = s == 1;
        t[6] = s != 1;
        return t;
    endfunction

    function automatic logic [6:0] gate_obs(input logic a, input logic b, input logic [6:0] m,
                                            input logic [6:0] v, input logic s, input logic [6:0] f);
        logic [6:0] t;
        t = truth(a, b);
        if (s) t = {t[5], t[6], t[4:0]};
        t = (t & ~m) | (v & m);
        return t ^ f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 10);
        localparam int S = (g == 2) ? 0 : 1;
        logic [6:0] obs_g;
        assign obs_g = gate_obs(a_o[g], b_o[g], sm[g], sv[g], sw[g], flip[g][{a_o[g], b_o[g]}]);

        logic_gate_tester #(.SETTLE_CYCLES(S), .LOOPS(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_i[g]),
            .a_out     (a_o[g]),
            .b_out     (b_o[g]),
            .and_in    (obs_g[0]),
            .or_in     (obs_g[1]),
            .not_in    (obs_g[2]),
            .nand_in   (obs_g[3]),
            .nor_in    (obs_g[4]),
            .xor_in    (obs_g[5]),
            .xnor_in   (obs_g[6]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .pass      (pass_o[g]),
            .fail_vec  (fail_o[g]),
            .err_count (err_o[g])
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
           ,.first_fail_valid (ffv_o[g]),
            .first_fail_idx   (ffi_o[g]),
            .first_fail_obs   (ffo_o[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_cfg(input int sel);
        sm[sel] = '0;
        sv[sel] = '0;
        sw[sel] = 1'b0;
        for (int v = 0; v < 4; v++) flip[sel][v] = '0;
    endtask

    // Reference: walk every loop and vector, compare model outputs with the truth table.
    task automatic ref_run(input int sel, output logic [6:0] f, output int e,
                           output logic fv, output logic [1:0] fi, output logic [6:0] fo);
        logic [6:0] o, t;
        f = '0; e = 0; fv = 1'b0; fi = '0; fo = '0;
        for (int l = 0; l < loops_of[sel]; l++) begin
            for (int v = 0; v < 4; v++) begin
                t = truth(v / 2 == 1, v % 2 == 1);
                o = gate_obs(v / 2 == 1, v % 2 == 1, sm[sel], sv[sel], sw[sel], flip[sel][v]);
                for (int g = 0; g < 7; g++) begin
                    if (o[g] != t[g]) begin
                        f[g] = 1'b1;
                        e++;
                    end
                end
                if (!fv && o != t) begin
                    fv = 1'b1;
                    fi = 2'(v);
                    fo = o;
                end
            end
        end
        if (e > 255) e = 255;
    endtask

    task automatic check_results(input int sel, input string tag);
        logic [6:0] f, fo;
        logic [1:0] fi;
        logic fv;
        int e;
        ref_run(sel, f, e, fv, fi, fo);
        check({tag, " fail_vec"}, 32'(fail_o[sel]), 32'(f));
        check({tag, " err_count"}, 32'(err_o[sel]), 32'(e));
        check({tag, " pass"}, 32'(pass_o[sel]), 32'(f == '0));
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
        check({tag, " ff_valid"}, 32'(ffv_o[sel]), 32'(fv));
        check({tag, " ff_idx"}, 32'(ffi_o[sel]), 32'(fi));
        check({tag, " ff_obs"}, 32'(ffo_o[sel]), 32'(fo));
`endif
    endtask

    // Called #1 after an edge with the checker idle; returns after done has dropped.
    task automatic run_one(input int sel, input string tag);
        int lat, exp_lat;
        exp_lat = 4 * loops_of[sel] * (settle_of[sel] + 2);
        lat = -1;
        ab_seq.delete();
        start_i[sel] = 1'b1;
        @(posedge clk); #1;
        start_i[sel] = 1'b0;
        ab_seq.push_back({a_o[sel], b_o[sel]});
        check({tag, " busy after accept"}, 32'(busy_o[sel]), 32'd1);
        for (int k = 1; k <= exp_lat + 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            ab_seq.push_back({a_o[sel], b_o[sel]});
            if (done_o[sel]) lat = k;
        end
        check({tag, " done latency"}, 32'(lat), 32'(exp_lat));
        if (lat >= 0) begin
            check({tag, " busy at done"}, 32'(busy_o[sel]), 32'd0);
            check_results(sel, tag);
            @(posedge clk); #1;
            check({tag, " done one cycle"}, 32'(done_o[sel]), 32'd0);
        end
    endtask

    initial begin
        int n_done;
        int done_at [$];
        rst     = 1'b1;
        start_i = '0;
        for (int s = 0; s < 3; s++) clear_cfg(s);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset busy[%0d]", s), 32'(busy_o[s]), 32'd0);
            check($sformatf("reset done[%0d]", s), 32'(done_o[s]), 32'd0);
            check($sformatf("reset ab[%0d]", s), 32'({a_o[s], b_o[s]}), 32'd0);
            check($sformatf("reset fail_vec[%0d]", s), 32'(fail_o[s]), 32'd0);
            check($sformatf("reset err[%0d]", s), 32'(err_o[s]), 32'd0);
            check($sformatf("reset pass[%0d]", s), 32'(pass_o[s]), 32'd1);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: healthy unit, default parameters
        run_one(0, "t1");
        if (ab_seq.size() > 12) begin
            check("t1 ab v0", 32'(ab_seq[0]), 32'd0);
            check("t1 ab v1", 32'(ab_seq[3]), 32'd1);
            check("t1 ab v2", 32'(ab_seq[6]), 32'd2);
            check("t1 ab v3", 32'(ab_seq[9]), 32'd3);
            check("t1 ab hold in done", 32'(ab_seq[12]), 32'd3);
        end
        check("t1 pass", 32'(pass_o[0]), 32'd1);

        // 2: NOT output tied low
        sm[0][2] = 1'b1;
        run_one(0, "t2");
        check("t2 fail_vec literal", 32'(fail_o[0]), 32'b0000100);
        check("t2 err literal", 32'(err_o[0]), 32'd2);

        // 3: XOR and XNOR swapped
        clear_cfg(0);
        sw[0] = 1'b1;
        run_one(0, "t3");
        check("t3 fail_vec literal", 32'(fail_o[0]), 32'b1100000);
        check("t3 err literal", 32'(err_o[0]), 32'd8);

        // 4: reset during SETTLE of vector 2
        clear_cfg(0);
        sm[0][2] = 1'b1;
        start_i[0] = 1'b1;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("t4 ab before rst", 32'({a_o[0], b_o[0]}), 32'd2);
        check("t4 err before rst", 32'(err_o[0]), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4 busy after rst", 32'(busy_o[0]), 32'd0);
        check("t4 ab after rst", 32'({a_o[0], b_o[0]}), 32'd0);
        check("t4 fail_vec after rst", 32'(fail_o[0]), 32'd0);
        check("t4 err after rst", 32'(err_o[0]), 32'd0);
        check("t4 pass after rst", 32'(pass_o[0]), 32'd1);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_o[0]) n_done++;
            @(posedge clk); #1;
        end
        check("t4 no done after rst", 32'(n_done), 32'd0);
        clear_cfg(0);
        run_one(0, "t4 rerun");
        check("t4 rerun pass", 32'(pass_o[0]), 32'd1);

        // 5: start held for 20 cycles; faulty NOT so results are visibly cleared
        sm[0][2] = 1'b1;
        start_i[0] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 19) start_i[0] = 1'b0;
            if (done_o[0]) done_at.push_back(k);
            if (k == 13) begin
                check("t5 start ignored in done", 32'(busy_o[0]), 32'd0);
                check("t5 results held", 32'(err_o[0]), 32'd2);
            end
            if (k == 14) begin
                check("t5 reaccepted", 32'(busy_o[0]), 32'd1);
                check("t5 err cleared", 32'(err_o[0]), 32'd0);
                check("t5 fail cleared", 32'(fail_o[0]), 32'd0);
            end
        end
        check("t5 done count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("t5 first done", 32'(done_at[0]), 32'd12);
            check("t5 second done", 32'(done_at[1]), 32'd26);
        end
        check("t5 final err", 32'(err_o[0]), 32'd2);

        // 6: LOOPS=3, AND stuck at 1
        sm[1][0] = 1'b1;
        sv[1][0] = 1'b1;
        run_one(1, "t6");
        check("t6 fail_vec literal", 32'(fail_o[1]), 32'b0000001);
        check("t6 err literal", 32'(err_o[1]), 32'd9);
`ifdef LOGIC_GATE_TESTER_FIRST_FAIL_EN
        check("t6 ff_idx literal", 32'(ffi_o[1]), 32'd0);
        check("t6 ff_obs bit0", 32'(ffo_o[1][0]), 32'd1);
`endif

        // Saturation with zero settle: every gate wrong on every vector for 10 loops
        for (int v = 0; v < 4; v++) flip[2][v] = 7'h7F;
        run_one(2, "sat");
        check("sat err literal", 32'(err_o[2]), 32'd255);
        check("sat fail literal", 32'(fail_o[2]), 32'h7F);

        // Randomised faults across all three instances
        for (int r = 0; r < 9; r++) begin
            int s;
            s = r % 3;
            clear_cfg(s);
            for (int v = 0; v < 4; v++) flip[s][v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
            if ($urandom_range(0, 1) == 1) begin
                sm[s] = 7'($urandom) & 7'($urandom);
                sv[s] = 7'($urandom);
            end
            sw[s] = 1'($urandom_range(0, 1));
            run_one(s, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
